// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the native valid/ready memory bus.
// Optional slave-hang watchdog: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    output logic        grant,
    output logic        busy,
    output logic        err_timeout
);

    // state | meaning
    // IDLE  | no owner; arbitrate among requesting masters
    // BUSY  | m[grant] is connected to the slave until s_ready/timeout/drop
    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nxt;
    logic        grant_nxt;
    logic        gnt_valid;
    logic [31:0] gnt_addr, gnt_wdata;
    logic [3:0]  gnt_wstrb;
    logic        expired;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT out of range 2..65535");
    end

    assign gnt_valid = grant ? m1_valid : m0_valid;
    assign gnt_addr  = grant ? m1_addr  : m0_addr;
    assign gnt_wdata = grant ? m1_wdata : m0_wdata;
    assign gnt_wstrb = grant ? m1_wstrb : m0_wstrb;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [15:0] to_cnt;

    // Counter value equals the number of stalled BUSY cycles already seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == IDLE) begin
            to_cnt <= '0;
        end else if (!s_ready && !expired) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    assign expired = (state == BUSY) && (to_cnt == 16'(TIMEOUT));
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= 1'b1;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    state_nxt = BUSY;
                    grant_nxt = (m0_valid && m1_valid) ? ~grant : m1_valid;
                end
            end
            BUSY: begin
                if (s_ready || expired || !gnt_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A real s_ready in the expiry cycle still counts as normal completion.
    assign rsp_ready = s_ready || expired;
    assign rsp_rdata = (expired && !s_ready) ? ERR_DATA : s_rdata;

    always_comb begin
        s_valid     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        m0_ready    = 1'b0;
        m0_rdata    = '0;
        m1_ready    = 1'b0;
        m1_rdata    = '0;
        err_timeout = 1'b0;
        busy        = (state == BUSY);
        if (state == BUSY) begin
            s_valid     = gnt_valid && !expired;
            s_addr      = gnt_addr;
            s_wdata     = gnt_wdata;
            s_wstrb     = gnt_wstrb;
            err_timeout = expired && !s_ready;
            if (grant) begin
                m1_ready = rsp_ready;
                m1_rdata = rsp_rdata;
            end else begin
                m0_ready = rsp_ready;
                m0_rdata = rsp_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle plus directed literals.
module tb_mem_arbiter;
    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_valid, m0_ready, m1_valid, m1_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        grant, busy, err_timeout;

    mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .grant(grant), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slave: raises s_ready once s_valid has been seen for lat cycles; hang holds it low.
    int   lat  = 0;
    bit   hang = 1'b0;
    int   vcnt = 0;
    logic sv_q = 1'b0, sr_q = 1'b0;
    always @(negedge clk) begin
        sv_q = s_valid;
        sr_q = s_ready;
    end
    always @(posedge clk) begin
        #1;
        if (!sv_q || sr_q) vcnt = 0;
        else vcnt++;
        s_ready = !hang && (vcnt >= lat);
    end

    int m0_pulses = 0, m1_pulses = 0;
    always @(negedge clk) begin
        if (m0_ready) m0_pulses++;
        if (m1_ready) m1_pulses++;
    end

    // Model: owner of the bus (-1 = none), last owner, stalled cycles of the current owner.
    int own = -1;
    bit last = 1'b1;
    int waited = 0;
    always @(negedge clk) begin : model
        logic        mv [2];
        logic [31:0] ad [2], wd [2];
        logic [3:0]  ws [2];
        logic        e_rdy [2];
        logic [31:0] e_rd [2];
        logic        e_sv, e_err, expd;
        logic [31:0] e_sa, e_swd;
        logic [3:0]  e_sws;
        if (!rst_n) begin
            own = -1; last = 1'b1; waited = 0;
            chk("rst_s_valid", 32'(s_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_grant", 32'(grant), 1);
            chk("rst_m0_ready", 32'(m0_ready), 0);
            chk("rst_m1_ready", 32'(m1_ready), 0);
            chk("rst_err", 32'(err_timeout), 0);
        end else begin
            mv[0] = m0_valid; mv[1] = m1_valid;
            ad[0] = m0_addr;  ad[1] = m1_addr;
            wd[0] = m0_wdata; wd[1] = m1_wdata;
            ws[0] = m0_wstrb; ws[1] = m1_wstrb;
            e_rdy[0] = 0; e_rdy[1] = 0; e_rd[0] = 0; e_rd[1] = 0;
            e_sv = 0; e_err = 0; e_sa = 0; e_swd = 0; e_sws = 0; expd = 0;
            if (own >= 0) begin
                expd       = TO_EN && (waited >= TO);
                e_sv       = mv[own] && !expd;
                e_sa       = ad[own];
                e_swd      = wd[own];
                e_sws      = ws[own];
                e_rdy[own] = s_ready || expd;
                e_rd[own]  = (expd && !s_ready) ? ERR : s_rdata;
                e_err      = expd && !s_ready;
            end
            chk("s_valid", 32'(s_valid), 32'(e_sv));
            chk("s_addr", s_addr, e_sa);
            chk("s_wdata", s_wdata, e_swd);
            chk("s_wstrb", 32'(s_wstrb), 32'(e_sws));
            chk("m0_ready", 32'(m0_ready), 32'(e_rdy[0]));
            chk("m0_rdata", m0_rdata, e_rd[0]);
            chk("m1_ready", 32'(m1_ready), 32'(e_rdy[1]));
            chk("m1_rdata", m1_rdata, e_rd[1]);
            chk("grant", 32'(grant), 32'(own >= 0 ? own : int'(last)));
            chk("busy", 32'(busy), 32'(own >= 0));
            chk("err_timeout", 32'(err_timeout), 32'(e_err));
            if (own < 0) begin
                if (mv[0] || mv[1]) begin
                    own    = (mv[0] && mv[1]) ? (last ? 0 : 1) : (mv[1] ? 1 : 0);
                    last   = own[0];
                    waited = 0;
                end
            end else if (s_ready || !mv[own] || expd) begin
                own = -1;
            end else begin
                waited++;
            end
        end
    end

    task automatic wait_rdy(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (m0_ready || m1_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("wait_ready_budget", 0, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        bit got;
        int p0, bc;
        rst_n = 1'b0;
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready = 0; s_rdata = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // m0 read, slave answers after 3 stalled cycles
        s_rdata = 32'h1234_5678; lat = 3;
        m0_addr = 32'h3000_0000; m0_wstrb = 4'b0000; m0_valid = 1;
        @(negedge clk);
        chk("t1_svalid_arb_cycle", 32'(s_valid), 0);
        tick();
        @(negedge clk);
        chk("t1_svalid_cycle1", 32'(s_valid), 1);
        wait_rdy(20, got);
        chk("t1_m0_rdata", m0_rdata, 32'h1234_5678);
        chk("t1_grant", 32'(grant), 0);
        tick();
        m0_valid = 0;
        tick(); tick();
        chk("t1_m0_pulses", 32'(m0_pulses), 1);

        // both masters continuously requesting: grants alternate from m0
        do_reset();
        lat = 1; s_rdata = 32'hA5A5_0001;
        m0_addr = 32'h0000_1000; m0_wdata = 32'h1111_1111; m0_wstrb = 4'hF;
        m1_addr = 32'h0000_2000; m1_wdata = 32'h2222_2222; m1_wstrb = 4'h0;
        m0_valid = 1; m1_valid = 1;
        for (int k = 0; k < 6; k++) begin
            wait_rdy(10, got);
            chk($sformatf("t2_grant_%0d", k), 32'(grant), 32'(k % 2));
            tick();
        end
        m0_valid = 0; m1_valid = 0;
        tick(); tick();

        // m1 write to a zero-wait slave while m0 stays idle
        p0 = m0_pulses;
        lat = 0;
        m1_addr = 32'h2000_0040; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'b0011; m1_valid = 1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("t3_m1_ready_first_busy", 32'(m1_ready), 1);
        chk("t3_s_wdata", s_wdata, 32'hCAFE_F00D);
        chk("t3_s_wstrb", 32'(s_wstrb), 32'h3);
        tick();
        m1_valid = 0;
        tick();

        // illegal valid drop while granted: no ready, back to IDLE
        lat = 5; m0_addr = 32'h0000_0080; m0_valid = 1;
        tick(); tick();
        m0_valid = 0;
        tick();
        @(negedge clk);
        chk("t3b_busy_after_drop", 32'(busy), 0);
        chk("t3b_m0_pulses", 32'(m0_pulses), 32'(p0));

        // asynchronous reset mid-transaction
        tick();
        m0_valid = 1; m1_valid = 1;
        tick(); tick();
        @(negedge clk);
        chk("t4_busy_before_rst", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        lat = 1;
        #1;
        chk("t4_async_svalid", 32'(s_valid), 0);
        chk("t4_async_busy", 32'(busy), 0);
        chk("t4_async_m0_ready", 32'(m0_ready), 0);
        chk("t4_async_m1_ready", 32'(m1_ready), 0);
        tick(); tick();
        rst_n = 1'b1;
        wait_rdy(10, got);
        chk("t4_m0_wins_after_rst", 32'(grant), 0);
        tick();
        m0_valid = 0; m1_valid = 0;
        tick(); tick();

        // hung slave
        hang = 1;
        tick();
        m0_addr = 32'h3000_0100; m0_valid = 1;
        tick();
        m1_valid = 1;
`ifdef MEM_ARB_TIMEOUT_EN
        bc = 0; got = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (err_timeout) begin got = 1; break; end
        end
        chk("t5_timeout_seen", 32'(got), 1);
        chk("t5_busy_cycle_of_timeout", 32'(bc), 9);
        chk("t5_m0_ready", 32'(m0_ready), 1);
        chk("t5_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        tick();
        m0_valid = 0;
        got = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (err_timeout) begin got = 1; break; end
        end
        chk("t5_second_timeout_seen", 32'(got), 1);
        chk("t5_m1_served_next", 32'(grant), 1);
        chk("t5_m1_ready", 32'(m1_ready), 1);
        tick();
        m1_valid = 0;
`else
        bc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("t5_no_err", 32'(err_timeout), 0);
            chk("t5_stays_busy", 32'(busy), 1);
        end
        tick();
        m0_valid = 0; m1_valid = 0;
`endif
        hang = 0;
        tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter for the native valid/ready memory bus used by the RISC-V core.
- Lets the CPU (m0) and a second requester (m1, e.g. DMA or debug loader) share a single slave, typically the PSRAM controller port.
- Uses round-robin arbitration. A grant is held for the whole transaction and released on the slave's ready.

Parameters:
TIMEOUT, 1024, max cycles a granted transaction may wait for s_ready before forced completion (used only with the optional feature; range 2..65535).
ERR_DATA, 32'hDEADBEEF, read data returned on a timed-out transaction.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
m0_valid  input  1  master 0 request; held high until m0_ready
m0_ready  output  1  master 0 transfer complete, 1-cycle pulse
m0_addr  input  32  master 0 byte address
m0_wdata  input  32  master 0 write data
m0_wstrb  input  4  master 0 byte strobes; 0 = read
m0_rdata  output  32  master 0 read data, valid with m0_ready
m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: same as m0, for master 1
s_valid  output  1  slave request
s_ready  input  1  slave transfer complete
s_addr  output  32  muxed address
s_wdata  output  32  muxed write data
s_wstrb  output  4  muxed strobes
s_rdata  input  32  slave read data
grant  output  1  current/last owner (0 = m0, 1 = m1)
busy  output  1  transaction in progress
err_timeout  output  1  1-cycle pulse on forced completion

Behaviour:
- Reset (async, rst_n=0): state=IDLE, grant=1 (so m0 wins the first tie), busy=0, err_timeout=0, timeout counter=0. All m*_ready=0, s_valid=0.
- State IDLE:
  - s_valid=0; s_addr/s_wdata/s_wstrb=0.
  - If exactly one m*_valid is high, that master is granted at the next edge.
  - If both are high, grant goes to the master not equal to the current grant (round-robin).
  - The granted master is registered into grant; state goes to BUSY, busy=1.
  - Arbitration costs exactly 1 cycle: m_valid at cycle N gives s_valid at cycle N+1.
- State BUSY (combinational outputs):
  - s_valid = m[grant]_valid.
  - s_addr, s_wdata, s_wstrb = m[grant] signals.
  - m[grant]_ready = s_ready.
  - m[grant]_rdata = s_rdata; the non-granted master sees ready=0 and rdata=0.
- BUSY exit on s_ready=1: state goes to IDLE at the same edge. s_valid is therefore low the following cycle, giving a 1-cycle gap between back-to-back transactions.
- Zero-wait-state slave: s_ready in the first BUSY cycle gives a 2-cycle total transaction.
- Back-to-back with both masters requesting: grants alternate m0, m1, m0, … No starvation; each master waits at most one transaction of the other.
- Illegal m[grant]_valid drop during BUSY (no s_ready): s_valid follows it low; state returns to IDLE next edge with no m*_ready pulse.
- A non-granted master's valid may rise or fall freely with no effect until IDLE.
- Simultaneous s_ready and timeout expiry: s_ready wins, normal completion, err_timeout=0.
- Reset mid-transaction: immediate return to reset values. The slave sees s_valid drop asynchronously; no ready is forwarded.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle with s_ready=0.
  - When it reaches TIMEOUT-1 with s_ready still 0, the next cycle drives m[grant]_ready=1, m[grant]_rdata=ERR_DATA, err_timeout=1, s_valid=0.
  - State then returns to IDLE.
- Undefined: no counter is built; err_timeout is tied 0; a hung slave blocks the arbiter indefinitely.

Test Plan:
- Reset, then m0 read at addr 32'h3000_0000 with slave ready after 3 cycles, s_rdata=32'h1234_5678: s_valid high from cycle 1; m0_ready pulses once with m0_rdata=32'h1234_5678; grant=0.
- m0 and m1 both asserted continuously, 6 transactions, slave ready 1 cycle after s_valid: grant sequence 0,1,0,1,0,1; 1-cycle s_valid gap between each.
- m1 write, wdata=32'hCAFE_F00D, wstrb=4'b0011, while m0 idle: s_wdata/s_wstrb match exactly; m0_ready never pulses.
- Assert rst_n=0 mid-BUSY: s_valid, busy and m*_ready go to 0 without a clock edge. After release, m0 wins a simultaneous request.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=8, slave never ready: m0_ready and err_timeout pulse together on the 9th BUSY cycle; m0_rdata=32'hDEADBEEF; arbiter returns to IDLE and serves m1 next.
- Without the macro, same stimulus: err_timeout stays 0 and busy stays 1 for 100 cycles.
